// File: rtl/ff_write_arbiter_pkg.sv
// Shared types and constants for the ff_write_arbiter block.
//   state_t : arbiter FSM states (IDLE, GRANT, ACK)
//   DEF_N   : default number of requesters
//   DEF_W   : default register data width
//   ptr_w() : width of the round-robin pointer / winner index for n requesters
package ff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    // Never returns 0, so two requesters still get a one-bit pointer.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ff_write_arbiter_if.sv
// Bundle between the requesters and the write arbiter.
//   req   : per-requester write request (bit i = requester i)
//   wdata : packed write data, requester i owns [i*W +: W]
//   gnt   : one-hot grant, high during the winner's write cycle
//   ack   : one-hot, one-cycle commit pulse
//   ff_en : enable to the shared register
//   ff_d  : data to the shared register
//   busy  : arbiter is in GRANT or ACK
// Modports: master = requester side, slave = arbiter side.
interface ff_write_arbiter_if
    import ff_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           ff_en;
    logic [W-1:0]   ff_d;
    logic           busy;

    modport master (
        output req, wdata,
        input  gnt, ack, ff_en, ff_d, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, ack, ff_en, ff_d, busy
    );
endinterface

// File: rtl/ff_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : position where the search starts (highest priority)
//   mask    : requests to ignore this cycle
//   win_oh  : one-hot winner
//   win_idx : winner index
//   valid   : at least one unmasked request exists
module ff_rr_pick
    import ff_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int PW = ptr_w(DEF_N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  win_oh,
    output logic [PW-1:0] win_idx,
    output logic          valid
);
    logic [N-1:0]  cand;
    logic [PW:0]   pos;
    logic [PW-1:0] idx;

    // NOTE: every variable written in this block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        cand    = req & ~mask;
        win_oh  = '0;
        win_idx = '0;
        valid   = 1'b0;
        pos     = '0;
        idx     = '0;
        // Walk ptr, ptr+1, ... wrapping modulo N; the first hit wins.
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (PW+1)'(i);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            idx = pos[PW-1:0];
            if (!valid && cand[idx]) begin
                valid       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end
endmodule

// File: rtl/ff_write_arbiter.sv
// Round-robin arbiter that is the sole driver of a shared enable-gated
// register (ff_en / ff_d). One winner per GRANT cycle, followed by a one-cycle
// ACK to that winner; all outputs come straight from flops.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : requester bundle (slave side), see ff_write_arbiter_if
module ff_write_arbiter
    import ff_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    ff_write_arbiter_if.slave bus
);
    localparam int PW = ptr_w(N);

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  ack_q, ack_d;
    logic          en_q, en_d;
    logic [W-1:0]  d_q, d_d;
    logic          busy_q, busy_d;
    logic          take;

    logic [N-1:0]  pick_oh;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;

    // ack_q is non-zero only in ACK and then holds the previous winner, which
    // is exactly the request to skip during re-arbitration. In IDLE it is zero,
    // so a sole requester is re-granted through IDLE.
    ff_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .mask    (ack_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        ack_d   = '0;
        en_d    = 1'b0;
        d_d     = d_q;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                take = pick_valid;
            end
            GRANT: begin
                // The write always completes, whatever req does now.
                state_d = ACK;
                ack_d   = gnt_q;
            end
            ACK: begin
                take = pick_valid;
                if (!pick_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            state_d = GRANT;
            gnt_d   = pick_oh;
            en_d    = 1'b1;
            d_d     = bus.wdata[pick_idx*W +: W];
            ptr_d   = (pick_idx == PW'(N-1)) ? '0 : pick_idx + PW'(1);
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.ff_en = en_q;
    assign bus.ff_d  = d_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_ff_write_arbiter.sv
// Directed bench for ff_write_arbiter (N=4, W=8). A table of per-cycle
// vectors covers round-robin, single writer, pointer wrap / masking and a
// mid-grant request drop; hand-written sequences cover the asynchronous
// resets. A model of the shared register (q) captures ff_d when ff_en is high.
module tb_ff_write_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    // Requester data: r3=D4, r2=A5, r1=B6, r0=C7. WD2 changes r3 only.
    localparam logic [31:0] WD  = 32'hD4A5_B6C7;
    localparam logic [31:0] WD2 = 32'h99A5_B6C7;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        en;
        logic [7:0]  d;
        logic        busy;
        logic [7:0]  q;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [7:0] q;

    int n_applied = 0;
    int n_miss    = 0;

    vec_t tv[$];

    ff_write_arbiter_if #(.N(N), .W(W)) bus ();

    ff_write_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared register bank the arbiter feeds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bus.ff_en) begin
            q <= bus.ff_d;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rq, input logic [31:0] wd,
                                input logic [3:0] g, input logic [3:0] a,
                                input logic e, input logic [7:0] d,
                                input logic b, input logic [7:0] qq);
        vec_t v;
        v.req = rq; v.wdata = wd; v.gnt = g; v.ack = a;
        v.en = e; v.d = d; v.busy = b; v.q = qq;
        return v;
    endfunction

    initial begin
        // Watchdog: the bench has no open-ended waits, this is only a guard.
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- table: req, wdata | gnt, ack, en, d, busy, q ----------------
        // All-request round-robin from ptr=0: 0,1,2,3,0,1,2,3, grant every 2 cycles.
        tv.push_back(mk(4'b1111, WD, 4'b0001, 4'b0000, 1, 8'hC7, 1, 8'h00));
        tv.push_back(mk(4'b1111, WD, 4'b0000, 4'b0001, 0, 8'hC7, 1, 8'hC7));
        tv.push_back(mk(4'b1111, WD, 4'b0010, 4'b0000, 1, 8'hB6, 1, 8'hC7));
        tv.push_back(mk(4'b1111, WD, 4'b0000, 4'b0010, 0, 8'hB6, 1, 8'hB6));
        tv.push_back(mk(4'b1111, WD, 4'b0100, 4'b0000, 1, 8'hA5, 1, 8'hB6));
        tv.push_back(mk(4'b1111, WD, 4'b0000, 4'b0100, 0, 8'hA5, 1, 8'hA5));
        tv.push_back(mk(4'b1111, WD, 4'b1000, 4'b0000, 1, 8'hD4, 1, 8'hA5));
        tv.push_back(mk(4'b1111, WD, 4'b0000, 4'b1000, 0, 8'hD4, 1, 8'hD4));
        tv.push_back(mk(4'b1111, WD, 4'b0001, 4'b0000, 1, 8'hC7, 1, 8'hD4));
        tv.push_back(mk(4'b1111, WD, 4'b0000, 4'b0001, 0, 8'hC7, 1, 8'hC7));
        tv.push_back(mk(4'b1111, WD, 4'b0010, 4'b0000, 1, 8'hB6, 1, 8'hC7));
        tv.push_back(mk(4'b1111, WD, 4'b0000, 4'b0010, 0, 8'hB6, 1, 8'hB6));
        tv.push_back(mk(4'b1111, WD, 4'b0100, 4'b0000, 1, 8'hA5, 1, 8'hB6));
        tv.push_back(mk(4'b1111, WD, 4'b0000, 4'b0100, 0, 8'hA5, 1, 8'hA5));
        tv.push_back(mk(4'b1111, WD, 4'b1000, 4'b0000, 1, 8'hD4, 1, 8'hA5));
        tv.push_back(mk(4'b1111, WD, 4'b0000, 4'b1000, 0, 8'hD4, 1, 8'hD4));
        tv.push_back(mk(4'b0000, WD, 4'b0000, 4'b0000, 0, 8'hD4, 0, 8'hD4));
        // Single writer 2 (ptr=0 -> 3).
        tv.push_back(mk(4'b0100, WD, 4'b0100, 4'b0000, 1, 8'hA5, 1, 8'hD4));
        tv.push_back(mk(4'b0100, WD, 4'b0000, 4'b0100, 0, 8'hA5, 1, 8'hA5));
        tv.push_back(mk(4'b0000, WD, 4'b0000, 4'b0000, 0, 8'hA5, 0, 8'hA5));
        // ptr=3, req=1001: grant 3 then 0 straight from ACK.
        tv.push_back(mk(4'b1001, WD, 4'b1000, 4'b0000, 1, 8'hD4, 1, 8'hA5));
        tv.push_back(mk(4'b1001, WD, 4'b0000, 4'b1000, 0, 8'hD4, 1, 8'hD4));
        tv.push_back(mk(4'b1001, WD, 4'b0001, 4'b0000, 1, 8'hC7, 1, 8'hD4));
        // Requester 3 drops and changes its data while not granted: no effect.
        tv.push_back(mk(4'b0001, WD2, 4'b0000, 4'b0001, 0, 8'hC7, 1, 8'hC7));
        // Sole requester 0 held: ACK -> IDLE -> GRANT, one write per 3 cycles.
        tv.push_back(mk(4'b0001, WD2, 4'b0000, 4'b0000, 0, 8'hC7, 0, 8'hC7));
        tv.push_back(mk(4'b0001, WD2, 4'b0001, 4'b0000, 1, 8'hC7, 1, 8'hC7));
        tv.push_back(mk(4'b0001, WD2, 4'b0000, 4'b0001, 0, 8'hC7, 1, 8'hC7));
        tv.push_back(mk(4'b0001, WD2, 4'b0000, 4'b0000, 0, 8'hC7, 0, 8'hC7));
        tv.push_back(mk(4'b0001, WD2, 4'b0001, 4'b0000, 1, 8'hC7, 1, 8'hC7));
        tv.push_back(mk(4'b0001, WD2, 4'b0000, 4'b0001, 0, 8'hC7, 1, 8'hC7));
        tv.push_back(mk(4'b0000, WD2, 4'b0000, 4'b0000, 0, 8'hC7, 0, 8'hC7));
        // Requester 1 drops req during its GRANT: write and ack still happen.
        tv.push_back(mk(4'b0010, WD2, 4'b0010, 4'b0000, 1, 8'hB6, 1, 8'hC7));
        tv.push_back(mk(4'b0000, WD2, 4'b0000, 4'b0010, 0, 8'hB6, 1, 8'hB6));
        tv.push_back(mk(4'b0000, WD2, 4'b0000, 4'b0000, 0, 8'hB6, 0, 8'hB6));

        // ---------------- reset, then asynchronous reset mid-cycle ----------------
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.wdata = WD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        @(posedge clk);
        #1;
        check("pre_reset.gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset.gnt",  32'(bus.gnt),   32'h0);
        check("async_reset.ack",  32'(bus.ack),   32'h0);
        check("async_reset.en",   32'(bus.ff_en), 32'h0);
        check("async_reset.d",    32'(bus.ff_d),  32'h0);
        check("async_reset.busy", 32'(bus.busy),  32'h0);
        @(posedge clk);
        #1;
        check("held_reset.gnt",  32'(bus.gnt),  32'h0);
        check("held_reset.busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < tv.size(); i++) begin
            if (i != 0) @(negedge clk);
            bus.req   = tv[i].req;
            bus.wdata = tv[i].wdata;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.gnt", i),  32'(bus.gnt),   32'(tv[i].gnt));
            check($sformatf("v%0d.ack", i),  32'(bus.ack),   32'(tv[i].ack));
            check($sformatf("v%0d.en", i),   32'(bus.ff_en), 32'(tv[i].en));
            check($sformatf("v%0d.d", i),    32'(bus.ff_d),  32'(tv[i].d));
            check($sformatf("v%0d.busy", i), 32'(bus.busy),  32'(tv[i].busy));
            check($sformatf("v%0d.q", i),    32'(q),         32'(tv[i].q));
        end

        // ---------------- reset during GRANT ----------------
        // ptr is 2 here; requester 2 wins.
        @(negedge clk);
        bus.req = 4'b0100;
        @(posedge clk);
        #1;
        check("rst_grant.pre_gnt", 32'(bus.gnt),   32'h4);
        check("rst_grant.pre_en",  32'(bus.ff_en), 32'h1);
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        check("rst_grant.en",   32'(bus.ff_en), 32'h0);
        check("rst_grant.gnt",  32'(bus.gnt),   32'h0);
        check("rst_grant.busy", 32'(bus.busy),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_grant.ack%0d", c),  32'(bus.ack),  32'h0);
            check($sformatf("rst_grant.busy%0d", c), 32'(bus.busy), 32'h0);
        end
        // Pointer is back to 0: requester 0 beats requester 3.
        @(negedge clk);
        bus.req = 4'b1001;
        @(posedge clk);
        #1;
        check("post_rst.gnt", 32'(bus.gnt),  32'h1);
        check("post_rst.d",   32'(bus.ff_d), 32'hC7);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end
endmodule
